// File: rtl/hilo_unit_if.sv
// EX-stage HI/LO port bundle: operation request, stall, architectural HI/LO and external multiplier link.
// slave is the HI/LO unit; master is the pipeline together with the combinational multiplier.
interface hilo_unit_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_sign;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;

  modport master (
    output op_valid, op, src_a, src_b, flush, mul_hi, mul_lo,
    input  stall_o, hi_o, lo_o, mul_a, mul_b, mul_sign
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush, mul_hi, mul_lo,
    output stall_o, hi_o, lo_o, mul_a, mul_b, mul_sign
  );
endinterface

// File: rtl/hilo_unit.sv
// MIPS HI/LO unit: MTHI/MTLO 1 cycle, MULT(U) 2 cycles via external multiplier, DIV(U) 34 cycles radix-2 restoring.
// Backpressure: stall_o holds the pipeline in the accept cycle of mul/div and through every DIV-state cycle; flush aborts.
module hilo_unit (
  input logic        clk,
  input logic        rst,
  hilo_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DFIX = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic [1:0]  state;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        signed_op;
  logic        sign_a;
  logic        sign_b;
  logic        div_zero;
  logic [4:0]  cnt;
  logic [63:0] rem;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        accept;
  logic        is_mul;
  logic        is_div;
  logic        div_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        fits;
  logic [31:0] sub_hi;
  logic [63:0] rem_next;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  always_comb begin
    accept     = (state == S_IDLE) && bus.op_valid && !bus.flush;
    is_mul     = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    is_div     = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    div_signed = (bus.op == OP_DIV);
    mag_a      = magnitude(bus.src_a, div_signed);
    mag_b      = magnitude(bus.src_b, div_signed);
  end

  // Shifted partial remainder is 33 bits wide; the 32-bit wrap of the
  // subtraction is exact whenever the trial subtraction succeeds.
  always_comb begin
    fits     = rem[63:31] >= {1'b0, op_b};
    sub_hi   = rem[62:31] - op_b;
    rem_next = fits ? {sub_hi, rem[30:0], 1'b1} : {rem[62:0], 1'b0};
  end

  always_comb begin
    quot_fix = (signed_op && (sign_a ^ sign_b)) ? (~rem[31:0] + 32'd1) : rem[31:0];
    rem_fix  = (signed_op && sign_a) ? (~rem[63:32] + 32'd1) : rem[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      signed_op <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      div_zero  <= 1'b0;
      cnt       <= 5'd0;
      rem       <= 64'd0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (bus.op == OP_MTHI) begin
              hi_r <= bus.src_a;
            end else if (bus.op == OP_MTLO) begin
              lo_r <= bus.src_a;
            end else if (is_mul) begin
              op_a      <= bus.src_a;
              op_b      <= bus.src_b;
              signed_op <= (bus.op == OP_MULT);
              state     <= S_MUL;
            end else if (is_div) begin
              op_a      <= mag_a;
              op_b      <= mag_b;
              signed_op <= div_signed;
              sign_a    <= div_signed && bus.src_a[31];
              sign_b    <= div_signed && bus.src_b[31];
              div_zero  <= (bus.src_b == 32'd0);
              rem       <= {32'd0, mag_a};
              cnt       <= 5'd0;
              state     <= S_DIV;
            end
          end
        end
        S_MUL: begin
          hi_r  <= bus.mul_hi;
          lo_r  <= bus.mul_lo;
          state <= S_IDLE;
        end
        S_DIV: begin
          rem <= rem_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_DFIX;
        end
        S_DFIX: begin
          // Divide by zero leaves |src_a| in the remainder; the sign fix restores src_a.
          hi_r  <= rem_fix;
          lo_r  <= div_zero ? 32'hFFFF_FFFF : quot_fix;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.stall_o  = (accept && (is_mul || is_div)) || ((state == S_DIV) && !bus.flush);
    bus.hi_o     = hi_r;
    bus.lo_o     = lo_r;
    bus.mul_a    = op_a;
    bus.mul_b    = op_b;
    bus.mul_sign = signed_op;
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed and random checks of hilo_unit against an arithmetic HI/LO reference model.
// The bench also plays the external combinational multiplier.
module tb_hilo_unit;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic [63:0] prod;

  hilo_unit_if bus ();

  hilo_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (bus.mul_sign)
      prod = 64'(longint'($signed(bus.mul_a)) * longint'($signed(bus.mul_b)));
    else
      prod = {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
  end
  assign bus.mul_hi = prod[63:32];
  assign bus.mul_lo = prod[31:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
    else     p = {32'd0, a} * {32'd0, b};
    exp_hi = p[63:32];
    exp_lo = p[31:0];
  endtask

  task automatic model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      exp_lo = 32'hFFFF_FFFF;
      exp_hi = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      exp_lo = q[31:0];
      exp_hi = r[31:0];
    end else begin
      exp_lo = a / b;
      exp_hi = a % b;
    end
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [31:0] v);
    bus.op_valid = 1'b1; bus.op = op; bus.src_a = v; bus.src_b = ~v;
    #1 chk("mt_stall", {31'd0, bus.stall_o}, 32'd0);
    tick();
    bus.op_valid = 1'b0;
    if (op == OP_MTHI) exp_hi = v; else exp_lo = v;
    chk("mt_hi", bus.hi_o, exp_hi);
    chk("mt_lo", bus.lo_o, exp_lo);
  endtask

  task automatic run_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    #1 chk("mul_accept_stall", {31'd0, bus.stall_o}, 32'd1);
    tick();
    bus.op_valid = 1'b0;
    chk("mul_busy_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("mul_a", bus.mul_a, a);
    chk("mul_b", bus.mul_b, b);
    chk("mul_sign", {31'd0, bus.mul_sign}, {31'd0, op == OP_MULT});
    chk("mul_no_early_hi", bus.hi_o, exp_hi);
    model_mul(op == OP_MULT, a, b);
    tick();
    chk("mul_hi", bus.hi_o, exp_hi);
    chk("mul_lo", bus.lo_o, exp_lo);
  endtask

  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int busy;
    busy = 0;
    bus.op_valid = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    #1 chk("div_accept_stall", {31'd0, bus.stall_o}, 32'd1);
    tick();
    bus.op_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (bus.stall_o === 1'b1) busy++;
      tick();
    end
    chk("div_busy_cycles", 32'(busy), 32'd32);
    chk("dfix_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("div_no_early_lo", bus.lo_o, exp_lo);
    model_div(op == OP_DIV, a, b);
    tick();
    chk("div_hi", bus.hi_o, exp_hi);
    chk("div_lo", bus.lo_o, exp_lo);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op = 3'd0; bus.src_a = 32'd0; bus.src_b = 32'd0; bus.flush = 1'b0;
    tick();
    tick();
    chk("reset_hi", bus.hi_o, 32'd0);
    chk("reset_lo", bus.lo_o, 32'd0);
    chk("reset_stall", {31'd0, bus.stall_o}, 32'd0);
    rst = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;

    run_mul(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    chk("mult_neg2x3_hi", bus.hi_o, 32'hFFFF_FFFF);
    chk("mult_neg2x3_lo", bus.lo_o, 32'hFFFF_FFFA);

    run_mul(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    chk("multu_hi", bus.hi_o, 32'd2);

    run_div(OP_DIVU, 32'd100, 32'd7);
    chk("divu_100_7_lo", bus.lo_o, 32'd14);
    chk("divu_100_7_hi", bus.hi_o, 32'd2);

    run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2_lo", bus.lo_o, 32'hFFFF_FFFD);
    chk("div_m7_2_hi", bus.hi_o, 32'hFFFF_FFFF);

    run_div(OP_DIVU, 32'd5, 32'd0);
    chk("divu_by0_lo", bus.lo_o, 32'hFFFF_FFFF);
    chk("divu_by0_hi", bus.hi_o, 32'd5);

    run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo", bus.lo_o, 32'h8000_0000);
    chk("div_ovf_hi", bus.hi_o, 32'd0);

    run_div(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    chk("div_neg_by0_lo", bus.lo_o, 32'hFFFF_FFFF);
    chk("div_neg_by0_hi", bus.hi_o, 32'hFFFF_FFF9);

    run_div(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001);

    // Flush in the eleventh DIV-state cycle.
    bus.op_valid = 1'b1; bus.op = OP_DIV; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    tick();
    bus.op_valid = 1'b0;
    repeat (10) tick();
    bus.flush = 1'b1;
    #1 chk("flush_div_stall", {31'd0, bus.stall_o}, 32'd0);
    tick();
    bus.flush = 1'b0;
    chk("flush_div_hi", bus.hi_o, exp_hi);
    chk("flush_div_lo", bus.lo_o, exp_lo);
    chk("flush_div_idle_stall", {31'd0, bus.stall_o}, 32'd0);
    run_mt(OP_MTLO, 32'h0000_1234);
    chk("mtlo_after_flush", bus.lo_o, 32'h0000_1234);

    bus.op_valid = 1'b1; bus.op = OP_MTHI; bus.src_a = 32'h0000_AAAA; bus.flush = 1'b1;
    tick();
    bus.op_valid = 1'b0; bus.flush = 1'b0;
    chk("mthi_flushed", bus.hi_o, exp_hi);

    // op_valid held through the MUL cycle must not be taken until the next cycle.
    bus.op_valid = 1'b1; bus.op = OP_MULT; bus.src_a = 32'd7; bus.src_b = 32'hFFFF_FFFB;
    tick();
    bus.op = OP_MTLO; bus.src_a = 32'h5555_0000;
    #1 chk("hold_mul_stall", {31'd0, bus.stall_o}, 32'd0);
    model_mul(1'b1, 32'd7, 32'hFFFF_FFFB);
    tick();
    chk("hold_mul_lo", bus.lo_o, exp_lo);
    chk("hold_mul_hi", bus.hi_o, exp_hi);
    tick();
    bus.op_valid = 1'b0;
    exp_lo = 32'h5555_0000;
    chk("hold_next_accept", bus.lo_o, exp_lo);

    bus.op_valid = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'd9; bus.src_b = 32'd9;
    tick();
    bus.op_valid = 1'b0; bus.flush = 1'b1;
    #1 chk("flush_mul_stall", {31'd0, bus.stall_o}, 32'd0);
    tick();
    bus.flush = 1'b0;
    chk("flush_mul_lo", bus.lo_o, exp_lo);
    chk("flush_mul_hi", bus.hi_o, exp_hi);

    bus.op_valid = 1'b1; bus.op = OP_MULT; bus.src_a = 32'd11; bus.src_b = 32'd13;
    tick();
    rst = 1'b1; bus.op = OP_MTHI; bus.flush = 1'b1;
    tick();
    rst = 1'b0; bus.op_valid = 1'b0; bus.flush = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    chk("rst_mul_hi", bus.hi_o, 32'd0);
    chk("rst_mul_lo", bus.lo_o, 32'd0);
    chk("rst_mul_stall", {31'd0, bus.stall_o}, 32'd0);
    tick();
    chk("rst_mul_stays_hi", bus.hi_o, 32'd0);

    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      case (rop)
        OP_MULT, OP_MULTU: run_mul(rop, ra, rb);
        OP_DIV, OP_DIVU:   run_div(rop, ra, rb);
        OP_MTHI, OP_MTLO:  run_mt(rop, ra);
        default: begin
          bus.op_valid = 1'b1; bus.op = rop; bus.src_a = ra; bus.src_b = rb;
          #1 chk("nop_stall", {31'd0, bus.stall_o}, 32'd0);
          tick();
          bus.op_valid = 1'b0;
          chk("nop_hi", bus.hi_o, exp_hi);
          chk("nop_lo", bus.lo_o, exp_lo);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
